// File: rtl/pointwise_conv_sched_pkg.sv
// Shared types and width helpers for the pointwise convolution scheduler.
package pointwise_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUTPUT,
    DONE
  } state_t;

  function automatic int unsigned pw_clog2(input int unsigned n);
    return (n <= 2) ? 1 : int'($clog2(n));
  endfunction

  function automatic int unsigned fm_aw(input int unsigned h, input int unsigned w,
                                        input int unsigned ic);
    return pw_clog2(h * w * ic);
  endfunction

  function automatic int unsigned wt_aw(input int unsigned oc, input int unsigned ic);
    return pw_clog2(oc * ic);
  endfunction

  function automatic int unsigned out_aw(input int unsigned h, input int unsigned w,
                                         input int unsigned oc);
    return pw_clog2(h * w * oc);
  endfunction

endpackage

// File: rtl/pointwise_conv_sched_delay.sv
// Fixed-depth shift register aligning {rd_en, first, last} with memory read data.
module pw_ctrl_delay #(
  parameter int unsigned DEPTH = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [2:0] d,
  output logic [2:0] q
);

  logic [2:0] sr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/pointwise_conv_sched.sv
// Walks (pixel, out channel, in channel) triples, issuing memory reads, MAC strobes
// and one valid/ready output word per (pixel, out channel).
module pointwise_conv_sched
  import pointwise_sched_pkg::*;
#(
  parameter int unsigned IN_CHANNELS  = 1,
  parameter int unsigned OUT_CHANNELS = 1,
  parameter int unsigned IN_HEIGHT    = 112,
  parameter int unsigned IN_WIDTH     = 112,
  parameter int unsigned MEM_LATENCY  = 1,
  localparam int unsigned FM_AW  = fm_aw(IN_HEIGHT, IN_WIDTH, IN_CHANNELS),
  localparam int unsigned WT_AW  = wt_aw(OUT_CHANNELS, IN_CHANNELS),
  localparam int unsigned OUT_AW = out_aw(IN_HEIGHT, IN_WIDTH, OUT_CHANNELS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              fm_rd_en,
  output logic [FM_AW-1:0]  fm_rd_addr,
  output logic              wt_rd_en,
  output logic [WT_AW-1:0]  wt_rd_addr,
  output logic              mac_en,
  output logic              acc_clr,
  output logic              acc_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_AW-1:0] out_addr
);

  localparam int unsigned NPIX = IN_HEIGHT * IN_WIDTH;
  localparam int unsigned PIXW = pw_clog2(NPIX);
  localparam int unsigned OCW  = pw_clog2(OUT_CHANNELS);
  localparam int unsigned ICW  = pw_clog2(IN_CHANNELS);
  localparam int unsigned DRW  = pw_clog2(MEM_LATENCY + 1);

  localparam logic [PIXW-1:0] PIX_LAST = PIXW'(NPIX - 1);
  localparam logic [OCW-1:0]  OC_LAST  = OCW'(OUT_CHANNELS - 1);
  localparam logic [ICW-1:0]  IC_LAST  = ICW'(IN_CHANNELS - 1);
  localparam logic [DRW-1:0]  DR_LAST  = DRW'(MEM_LATENCY);

  state_t          state_q, state_d;
  logic [PIXW-1:0] pix_q, pix_d;
  logic [OCW-1:0]  oc_q, oc_d;
  logic [ICW-1:0]  ic_q, ic_d;
  logic [DRW-1:0]  drain_q, drain_d;
  logic            busy_q, done_q, rd_en_q, out_valid_q;
  logic [2:0]      dly_q;

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    oc_d    = oc_q;
    ic_d    = ic_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          pix_d   = '0;
          oc_d    = '0;
          ic_d    = '0;
          drain_d = '0;
        end
      end
      ISSUE: begin
        if (ic_q == IC_LAST) begin
          ic_d    = '0;
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          ic_d = ic_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DR_LAST) begin
          drain_d = '0;
          state_d = OUTPUT;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          state_d = ISSUE;
          if (oc_q == OC_LAST) begin
            oc_d = '0;
            if (pix_q == PIX_LAST) begin
              pix_d   = '0;
              state_d = DONE;
            end else begin
              pix_d = pix_q + 1'b1;
            end
          end else begin
            oc_d = oc_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      pix_d   = '0;
      oc_d    = '0;
      ic_d    = '0;
      drain_d = '0;
    end
  end

  // Strobes are registered from the next-state decode so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      pix_q       <= '0;
      oc_q        <= '0;
      ic_q        <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      oc_q        <= oc_d;
      ic_q        <= ic_d;
      drain_q     <= drain_d;
      busy_q      <= (state_d == ISSUE) || (state_d == DRAIN) || (state_d == OUTPUT);
      done_q      <= (state_d == DONE);
      rd_en_q     <= (state_d == ISSUE);
      out_valid_q <= (state_d == OUTPUT);
    end
  end

  pw_ctrl_delay #(.DEPTH(MEM_LATENCY)) u_delay (
    .clk (clk),
    .clr (abort || !rst),
    .d   ({rd_en_q, rd_en_q && (ic_q == '0), rd_en_q && (ic_q == IC_LAST)}),
    .q   (dly_q)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign fm_rd_en   = rd_en_q;
  assign wt_rd_en   = rd_en_q;
  assign out_valid  = out_valid_q;
  assign mac_en     = dly_q[2];
  assign acc_clr    = dly_q[1];
  assign acc_last   = dly_q[0];
  assign fm_rd_addr = FM_AW'(32'(pix_q) * IN_CHANNELS + 32'(ic_q));
  assign wt_rd_addr = WT_AW'(32'(oc_q) * IN_CHANNELS + 32'(ic_q));
  assign out_addr   = OUT_AW'(32'(pix_q) * OUT_CHANNELS + 32'(oc_q));

endmodule

// File: tb/tb_pointwise_conv_sched.sv
// Directed bench: three scheduler configurations share stimulus; each task checks one.
module tb_pointwise_conv_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic out_ready = 1'b1;

  // A: IC4 OC2 H2 W2 ML1
  logic a_busy, a_done, a_fm_rd_en, a_wt_rd_en, a_mac_en, a_acc_clr, a_acc_last, a_out_valid;
  logic [3:0] a_fm_rd_addr;
  logic [2:0] a_wt_rd_addr;
  logic [2:0] a_out_addr;
  // B: IC3 OC1 H1 W2 ML2
  logic b_busy, b_done, b_fm_rd_en, b_wt_rd_en, b_mac_en, b_acc_clr, b_acc_last, b_out_valid;
  logic [2:0] b_fm_rd_addr;
  logic [1:0] b_wt_rd_addr;
  logic [0:0] b_out_addr;
  // C: IC1 OC2 H1 W2 ML1
  logic c_busy, c_done, c_fm_rd_en, c_wt_rd_en, c_mac_en, c_acc_clr, c_acc_last, c_out_valid;
  logic [0:0] c_fm_rd_addr;
  logic [0:0] c_wt_rd_addr;
  logic [1:0] c_out_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  pointwise_conv_sched #(.IN_CHANNELS(4), .OUT_CHANNELS(2), .IN_HEIGHT(2), .IN_WIDTH(2),
                         .MEM_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(a_busy), .done(a_done),
    .fm_rd_en(a_fm_rd_en), .fm_rd_addr(a_fm_rd_addr), .wt_rd_en(a_wt_rd_en),
    .wt_rd_addr(a_wt_rd_addr), .mac_en(a_mac_en), .acc_clr(a_acc_clr), .acc_last(a_acc_last),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_addr(a_out_addr));

  pointwise_conv_sched #(.IN_CHANNELS(3), .OUT_CHANNELS(1), .IN_HEIGHT(1), .IN_WIDTH(2),
                         .MEM_LATENCY(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(b_busy), .done(b_done),
    .fm_rd_en(b_fm_rd_en), .fm_rd_addr(b_fm_rd_addr), .wt_rd_en(b_wt_rd_en),
    .wt_rd_addr(b_wt_rd_addr), .mac_en(b_mac_en), .acc_clr(b_acc_clr), .acc_last(b_acc_last),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_addr(b_out_addr));

  pointwise_conv_sched #(.IN_CHANNELS(1), .OUT_CHANNELS(2), .IN_HEIGHT(1), .IN_WIDTH(2),
                         .MEM_LATENCY(1)) dut_c (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(c_busy), .done(c_done),
    .fm_rd_en(c_fm_rd_en), .fm_rd_addr(c_fm_rd_addr), .wt_rd_en(c_wt_rd_en),
    .wt_rd_addr(c_wt_rd_addr), .mac_en(c_mac_en), .acc_clr(c_acc_clr), .acc_last(c_acc_last),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_addr(c_out_addr));

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Start high during cycle 0; returns at cycle 1.
  task automatic launch();
    start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200; k++) begin
      if (!a_busy && !b_busy && !c_busy && !a_done && !b_done && !c_done) break;
      step();
    end
    checks++;
    if (k >= 200) begin
      errors++;
      $display("FAIL wait_idle: busy=%b%b%b required 000 within 200 cycles", a_busy, b_busy, c_busy);
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    checks++;
    if ({a_busy, a_done, a_fm_rd_en, a_wt_rd_en, a_mac_en, a_acc_clr, a_acc_last, a_out_valid}
        !== 8'h00) begin
      errors++;
      $display("FAIL reset_a_ctrl: got %b required 00000000",
               {a_busy, a_done, a_fm_rd_en, a_wt_rd_en, a_mac_en, a_acc_clr, a_acc_last, a_out_valid});
    end
    checks++;
    if ({a_fm_rd_addr, a_wt_rd_addr, a_out_addr} !== 10'h0) begin
      errors++;
      $display("FAIL reset_a_addr: got fm=%0d wt=%0d out=%0d required 0", a_fm_rd_addr,
               a_wt_rd_addr, a_out_addr);
    end
    checks++;
    if ({b_busy, b_done, b_fm_rd_en, b_wt_rd_en, b_mac_en, b_acc_clr, b_acc_last, b_out_valid,
         b_fm_rd_addr, b_wt_rd_addr, b_out_addr,
         c_busy, c_done, c_fm_rd_en, c_wt_rd_en, c_mac_en, c_acc_clr, c_acc_last, c_out_valid,
         c_fm_rd_addr, c_wt_rd_addr, c_out_addr} !== 30'h0) begin
      errors++;
      $display("FAIL reset_bc: b/c outputs nonzero, required all 0");
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_full_pass();
    int done_cyc = 0;
    int n_hs = 0;
    int bad_wt = 0;
    launch();
    for (int k = 0; k < 200 && done_cyc == 0; k++) begin
      if (a_wt_rd_en !== a_fm_rd_en) bad_wt++;
      if (a_out_valid && out_ready) begin
        checks++;
        if (a_out_addr !== 3'(n_hs)) begin
          errors++;
          $display("FAIL pass_out_addr: got %0d required %0d", a_out_addr, n_hs);
        end
        n_hs++;
      end
      if (a_done) done_cyc = cyc;
      else step();
    end
    checks++;
    if (done_cyc != 57) begin
      errors++;
      $display("FAIL pass_done_cycle: got %0d required 57", done_cyc);
    end
    checks++;
    if (n_hs != 8) begin
      errors++;
      $display("FAIL pass_handshakes: got %0d required 8", n_hs);
    end
    checks++;
    if (bad_wt != 0) begin
      errors++;
      $display("FAIL pass_wt_rd_en: %0d cycles differ from fm_rd_en, required 0", bad_wt);
    end
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL pass_busy_in_done: got %b required 0", a_busy);
    end
    step();
    checks++;
    if (a_done !== 1'b0) begin
      errors++;
      $display("FAIL pass_done_pulse: got %b required 0 one cycle later", a_done);
    end
    wait_idle();
  endtask

  task automatic test_align();
    launch();
    for (int c = 1; c <= 7; c++) begin
      logic exp_rd, exp_mac, exp_clr, exp_last, exp_ov;
      exp_rd   = (c <= 3);
      exp_mac  = (c >= 3 && c <= 5);
      exp_clr  = (c == 3);
      exp_last = (c == 5);
      exp_ov   = (c == 7);
      checks++;
      if ({b_fm_rd_en, b_wt_rd_en, b_mac_en, b_acc_clr, b_acc_last, b_out_valid} !==
          {exp_rd, exp_rd, exp_mac, exp_clr, exp_last, exp_ov}) begin
        errors++;
        $display("FAIL align_ctrl cycle %0d: got rd/wt/mac/clr/last/ov=%b required %b", c,
                 {b_fm_rd_en, b_wt_rd_en, b_mac_en, b_acc_clr, b_acc_last, b_out_valid},
                 {exp_rd, exp_rd, exp_mac, exp_clr, exp_last, exp_ov});
      end
      if (exp_rd) begin
        checks++;
        if (b_fm_rd_addr !== 3'(c - 1) || b_wt_rd_addr !== 2'(c - 1)) begin
          errors++;
          $display("FAIL align_addr cycle %0d: got fm=%0d wt=%0d required %0d", c,
                   b_fm_rd_addr, b_wt_rd_addr, c - 1);
        end
      end
      step();
    end
    wait_idle();
  endtask

  task automatic test_ic1();
    int n_mac = 0;
    int stray = 0;
    launch();
    for (int k = 0; k < 40; k++) begin
      if (c_mac_en) begin
        checks++;
        if ({c_acc_clr, c_acc_last} !== 2'b11) begin
          errors++;
          $display("FAIL ic1_clr_last: got %b required 11", {c_acc_clr, c_acc_last});
        end
        n_mac++;
      end else if (c_acc_clr || c_acc_last) begin
        stray++;
      end
      step();
    end
    checks++;
    if (n_mac != 4 || stray != 0) begin
      errors++;
      $display("FAIL ic1_mac_count: got %0d macs %0d stray required 4 and 0", n_mac, stray);
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    int done_cyc = 0;
    launch();
    for (int k = 0; k < 20 && !a_out_valid; k++) step();
    checks++;
    if (cyc != 7 || a_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_valid: got cycle %0d valid %b required 7 and 1", cyc, a_out_valid);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({a_out_valid, a_fm_rd_en, a_mac_en} !== 3'b100 || a_out_addr !== 3'd0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got valid/rd/mac=%b addr=%0d required 100 addr 0",
                 cyc, {a_out_valid, a_fm_rd_en, a_mac_en}, a_out_addr);
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 200 && done_cyc == 0; k++) begin
      if (a_done) done_cyc = cyc;
      else step();
    end
    checks++;
    if (done_cyc != 62) begin
      errors++;
      $display("FAIL bp_done_cycle: got %0d required 62", done_cyc);
    end
    wait_idle();
  endtask

  task automatic test_abort();
    int bad = 0;
    launch();
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({a_busy, a_fm_rd_en, a_mac_en, a_out_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_next: got busy/rd/mac/ov=%b required 0000",
               {a_busy, a_fm_rd_en, a_mac_en, a_out_valid});
    end
    for (int k = 0; k < 70; k++) begin
      if (a_mac_en || a_out_valid || a_done || a_busy) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d active cycles required 0", bad);
    end
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if ({a_busy, a_fm_rd_en} !== 2'b00) begin
      errors++;
      $display("FAIL abort_beats_start: got busy/rd=%b required 00", {a_busy, a_fm_rd_en});
    end
    launch();
    checks++;
    if (a_fm_rd_en !== 1'b1 || a_fm_rd_addr !== 4'd0) begin
      errors++;
      $display("FAIL abort_restart: got rd=%b addr=%0d required 1 addr 0", a_fm_rd_en,
               a_fm_rd_addr);
    end
    wait_idle();
  endtask

  task automatic test_start_ignored();
    int done_cyc = 0;
    int extra = 0;
    launch();
    for (int k = 0; k < 200 && done_cyc == 0; k++) begin
      if (a_done) done_cyc = cyc;
      else begin
        start = (cyc == 10 || cyc == 30);
        step();
      end
    end
    start = 1'b0;
    checks++;
    if (done_cyc != 57) begin
      errors++;
      $display("FAIL ignore_done_cycle: got %0d required 57", done_cyc);
    end
    step();
    for (int k = 0; k < 10; k++) begin
      if (a_busy || a_done) extra++;
      step();
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignore_no_rerun: got %0d busy cycles required 0", extra);
    end
    wait_idle();
  endtask

  task automatic test_rst_output();
    int n_ov = 0;
    launch();
    for (int k = 0; k < 40; k++) begin
      if (a_out_valid) n_ov++;
      if (n_ov == 2) break;
      step();
    end
    checks++;
    if (n_ov != 2 || cyc != 14 || a_out_addr !== 3'd1 || a_wt_rd_addr !== 3'd4) begin
      errors++;
      $display("FAIL rst_pre: got words=%0d cycle=%0d out=%0d wt=%0d required 2 14 1 4", n_ov,
               cyc, a_out_addr, a_wt_rd_addr);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({a_busy, a_done, a_fm_rd_en, a_wt_rd_en, a_mac_en, a_acc_clr, a_acc_last, a_out_valid,
         a_fm_rd_addr, a_wt_rd_addr, a_out_addr} !== 18'h0) begin
      errors++;
      $display("FAIL rst_in_output: got %b required all 0",
               {a_busy, a_done, a_fm_rd_en, a_wt_rd_en, a_mac_en, a_acc_clr, a_acc_last,
                a_out_valid, a_fm_rd_addr, a_wt_rd_addr, a_out_addr});
    end
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({a_busy, a_out_valid, a_mac_en} !== 3'b000) begin
      errors++;
      $display("FAIL rst_release_idle: got busy/ov/mac=%b required 000",
               {a_busy, a_out_valid, a_mac_en});
    end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_align();
    test_ic1();
    test_backpressure();
    test_abort();
    test_start_ignored();
    test_rst_output();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
